// File: rtl/uart_core_p_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_p_if
// Purpose  : Host-side and serial-line signals of the UART core, grouped so a
//            single port carries the whole bus.
//            master : host / line driver (baud_div, rxd, tx_data, tx_wr_en,
//                     rx_rd_en, err_clr out; status, txd, rx_data in)
//            slave  : the UART core (the mirror image)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_core_p_if #(
    parameter int D_W   = 8,
    parameter int DEPTH = 64,
    parameter int DIV_W = 16
);
    localparam int c_lw = $clog2(DEPTH) + 1;

    logic [DIV_W-1:0] baud_div;
    logic             rxd;
    logic             txd;
    logic [D_W-1:0]   tx_data;
    logic             tx_wr_en;
    logic             tx_full;
    logic             tx_busy;
    logic             tx_done;
    logic [D_W-1:0]   rx_data;
    logic             rx_rd_en;
    logic             rx_empty;
    logic [c_lw-1:0]  rx_level;
    logic [c_lw-1:0]  tx_level;
    logic             rx_parity_err;
    logic             rx_frame_err;
    logic             rx_overrun;
    logic             err_clr;

    modport master (
        output baud_div, rxd, tx_data, tx_wr_en, rx_rd_en, err_clr,
        input  txd, tx_full, tx_busy, tx_done, rx_data, rx_empty,
               rx_level, tx_level, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  baud_div, rxd, tx_data, tx_wr_en, rx_rd_en, err_clr,
        output txd, tx_full, tx_busy, tx_done, rx_data, rx_empty,
               rx_level, tx_level, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_core_p.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_p_fifo / uart_core_p
// Purpose  : UART with shared oversampling tick, TX and RX FIFOs, optional
//            parity, 1 or 2 stop bits and sticky receive error flags.
//            Ports: clk, rst (async, active-high), bus (uart_core_p_if.slave).
//            FIFO ports: i_wr_en/i_wr_data push, i_rd_en pop, o_rd_data is the
//            head word, o_full/o_empty/o_level status.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_p_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [W-1:0]           i_wr_data,
    input  logic                   i_rd_en,
    output logic [W-1:0]           o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int c_aw = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [c_aw:0] wp_q, wp_d, rp_q, rp_d;
    logic          w_do_rd, w_do_wr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        o_level   = wp_q - rp_q;
        o_empty   = (wp_q == rp_q);
        o_full    = (wp_q == {~rp_q[c_aw], rp_q[c_aw-1:0]});
        o_rd_data = mem_q[rp_q[c_aw-1:0]];
        w_do_rd   = i_rd_en && !o_empty;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        w_do_wr   = i_wr_en && (!o_full || w_do_rd);
        wp_d      = w_do_wr ? wp_q + 1'b1 : wp_q;
        rp_d      = w_do_rd ? rp_q + 1'b1 : rp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) mem_q[wp_q[c_aw-1:0]] <= i_wr_data;
    end
endmodule

module uart_core_p #(
    parameter int D_W       = 8,
    parameter int B_TICK    = 16,
    parameter int DEPTH     = 64,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_core_p_if.slave bus
);
    localparam int                c_tw    = $clog2(B_TICK);
    localparam logic [c_tw-1:0]   c_tlast = c_tw'(B_TICK - 1);
    localparam logic [c_tw-1:0]   c_thalf = c_tw'(B_TICK / 2 - 1);
    localparam logic [3:0]        c_dlast = 4'(D_W - 1);
    localparam logic [3:0]        c_slast = 4'(STOP_BITS - 1);
    localparam logic              c_odd   = (PARITY == 2);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Tick generator, synchroniser, receive data register and error flags
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [1:0]       sync_q, sync_d;
    logic [D_W-1:0]   rx_data_q, rx_data_d;
    logic             perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

    // TX and RX state machines
    state_t           tx_st_q, rx_st_q;
    logic [c_tw-1:0]  tx_tcnt_q, rx_tcnt_q;
    logic [3:0]       tx_bcnt_q, rx_bcnt_q;
    logic [D_W-1:0]   tx_sh_q, rx_sh_q;
    logic             tx_par_q, txd_q, tx_busy_q, tx_done_q;

    logic             w_tick, w_rxs, w_tx_bit_end, w_tx_last_stop, w_tx_pop;
    logic             w_rx_samp, w_rx_push, w_perr_set, w_ovr_set;
    logic             w_tx_empty, w_rx_empty, w_rx_full;
    logic [D_W-1:0]   w_tx_rdata, w_rx_rdata;

    always_comb begin
        w_tick         = (cnt_q == div_q);
        cnt_d          = w_tick ? '0 : cnt_q + 1'b1;
        // The divisor is latched only on reload so a change never truncates a tick.
        div_d          = w_tick ? bus.baud_div : div_q;
        sync_d         = {sync_q[0], bus.rxd};
        w_rxs          = sync_q[1];
        w_tx_bit_end   = w_tick && (tx_tcnt_q == c_tlast);
        w_tx_last_stop = (tx_st_q == ST_STOP) && w_tx_bit_end && (tx_bcnt_q == c_slast);
        // Words are popped on a tick, so the start bit spans exactly B_TICK ticks;
        // popping at the end of the last stop bit chains frames with no gap.
        w_tx_pop       = !w_tx_empty && (((tx_st_q == ST_IDLE) && w_tick) || w_tx_last_stop);
        w_rx_samp      = w_tick && (rx_tcnt_q == c_tlast);
        w_rx_push      = (rx_st_q == ST_STOP) && w_rx_samp;
        w_perr_set     = (rx_st_q == ST_PARITY) && w_rx_samp && (w_rxs != ((^rx_sh_q) ^ c_odd));
        // A same-cycle host pop makes room, so only an unrelieved full FIFO drops.
        w_ovr_set      = w_rx_push && w_rx_full && !bus.rx_rd_en;
        rx_data_d      = (bus.rx_rd_en && !w_rx_empty) ? w_rx_rdata : rx_data_q;
        perr_d         = (perr_q && !bus.err_clr) || w_perr_set;
        ferr_d         = (ferr_q && !bus.err_clr) || (w_rx_push && !w_rxs);
        ovr_d          = (ovr_q  && !bus.err_clr) || w_ovr_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= '0;
            sync_q    <= 2'b11;
            rx_data_q <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sync_q    <= sync_d;
            rx_data_q <= rx_data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q   <= ST_IDLE;
            tx_tcnt_q <= '0;
            tx_bcnt_q <= '0;
            tx_sh_q   <= '0;
            tx_par_q  <= 1'b0;
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= w_tx_last_stop;
            if (w_tx_pop) begin
                tx_st_q   <= ST_START;
                tx_tcnt_q <= '0;
                tx_sh_q   <= w_tx_rdata;
                tx_par_q  <= (^w_tx_rdata) ^ c_odd;
                txd_q     <= 1'b0;
                tx_busy_q <= 1'b1;
            end else if (w_tx_bit_end && (tx_st_q != ST_IDLE)) begin
                tx_tcnt_q <= '0;
                case (tx_st_q)
                    ST_START: begin
                        tx_st_q   <= ST_DATA;
                        tx_bcnt_q <= '0;
                        txd_q     <= tx_sh_q[0];
                    end
                    ST_DATA: begin
                        if (tx_bcnt_q == c_dlast) begin
                            tx_bcnt_q <= '0;
                            tx_st_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            txd_q     <= (PARITY != 0) ? tx_par_q : 1'b1;
                        end else begin
                            tx_bcnt_q <= tx_bcnt_q + 1'b1;
                            tx_sh_q   <= tx_sh_q >> 1;
                            txd_q     <= tx_sh_q[1];
                        end
                    end
                    ST_PARITY: begin
                        tx_st_q <= ST_STOP;
                        txd_q   <= 1'b1;
                    end
                    ST_STOP: begin
                        if (tx_bcnt_q == c_slast) begin
                            tx_st_q   <= ST_IDLE;
                            tx_busy_q <= 1'b0;
                        end else begin
                            tx_bcnt_q <= tx_bcnt_q + 1'b1;
                        end
                    end
                    default: tx_st_q <= ST_IDLE;
                endcase
            end else if (w_tick && (tx_st_q != ST_IDLE)) begin
                tx_tcnt_q <= tx_tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st_q   <= ST_IDLE;
            rx_tcnt_q <= '0;
            rx_bcnt_q <= '0;
            rx_sh_q   <= '0;
        end else begin
            case (rx_st_q)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        rx_st_q   <= ST_START;
                        rx_tcnt_q <= '0;
                    end
                end
                ST_START: begin
                    // Half a bit in: still low means a real start bit, and all
                    // later samples land mid-bit.
                    if (w_tick) begin
                        if (rx_tcnt_q == c_thalf) begin
                            rx_tcnt_q <= '0;
                            rx_bcnt_q <= '0;
                            rx_st_q   <= w_rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_rx_samp) begin
                        rx_tcnt_q <= '0;
                        case (rx_st_q)
                            ST_DATA: begin
                                rx_sh_q <= {w_rxs, rx_sh_q[D_W-1:1]};
                                if (rx_bcnt_q == c_dlast) begin
                                    rx_st_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                                end else begin
                                    rx_bcnt_q <= rx_bcnt_q + 1'b1;
                                end
                            end
                            ST_PARITY: rx_st_q <= ST_STOP;
                            // Only the first stop bit is checked; the line is
                            // high from here on, so IDLE is safe mid-stop.
                            default:   rx_st_q <= ST_IDLE;
                        endcase
                    end else if (w_tick) begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_core_p_fifo #(.W(D_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.tx_wr_en),
        .i_wr_data (bus.tx_data),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_rdata),
        .o_full    (bus.tx_full),
        .o_empty   (w_tx_empty),
        .o_level   (bus.tx_level)
    );

    uart_core_p_fifo #(.W(D_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_rx_push),
        .i_wr_data (rx_sh_q),
        .i_rd_en   (bus.rx_rd_en),
        .o_rd_data (w_rx_rdata),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_level   (bus.rx_level)
    );

    assign bus.txd           = txd_q;
    assign bus.tx_busy       = tx_busy_q;
    assign bus.tx_done       = tx_done_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_empty      = w_rx_empty;
    assign bus.rx_parity_err = perr_q;
    assign bus.rx_frame_err  = ferr_q;
    assign bus.rx_overrun    = ovr_q;
endmodule
`default_nettype wire
